// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Fetch program-counter generator for the IF stage of a MIPS pipeline.
// Chooses the next PC from exception, buffered redirect, jr/jalr, j/jal,
// taken branch or sequential fetch. A redirect seen while stalled is
// buffered until the stall releases. Flush/Misalign pulse for one cycle
// whenever a redirect is actually applied to PC.
module pc_fetch_unit #(
   parameter int unsigned ADDR_W       = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
   parameter int unsigned PC_STEP      = 4
) (
   input  logic              Clk,
   input  logic              PcReSet,
   input  logic              Stall,
   input  logic              Exception,
   input  logic              JumpReg,
   input  logic [ADDR_W-1:0] JumpRegAddr,
   input  logic              Jump,
   input  logic [25:0]       JumpIndex,
   input  logic              BranchTaken,
   input  logic [15:0]       BranchOffset,
   input  logic [ADDR_W-1:0] RedirBasePc,
   output logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] PcPlus4,
   output logic              FetchValid,
   output logic              Flush,
   output logic              Misalign,
   output logic              RedirPending
);

   localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VECTOR);
   localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VECTOR);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
   // Bits [27:0] of a j/jal target come from the instruction; the rest from the base PC.
   localparam logic [ADDR_W-1:0] LOW28    = ADDR_W'(28'hFFF_FFFF);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic              flush_q, flush_d;
   logic              mis_q, mis_d;
   logic              pend_v_q, pend_v_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
   logic              pend_mis_q, pend_mis_d;

   logic [ADDR_W-1:0] branch_tgt;
   logic [ADDR_W-1:0] jump_tgt;
   logic [ADDR_W-1:0] jreg_tgt;
   logic              jreg_mis;
   logic              redir_any;
   logic [ADDR_W-1:0] redir_tgt;
   logic              redir_mis;

   assign branch_tgt = RedirBasePc
                     + {{(ADDR_W-18){BranchOffset[15]}}, BranchOffset, 2'b00};
   assign jump_tgt   = (RedirBasePc & ~LOW28) | ADDR_W'({JumpIndex, 2'b00});
   assign jreg_tgt   = {JumpRegAddr[ADDR_W-1:2], 2'b00};
   assign jreg_mis   = |JumpRegAddr[1:0];

   // Pick the highest-priority non-exception redirect: jr > j > branch.
   always_comb begin
      redir_any = JumpReg | Jump | BranchTaken;
      redir_tgt = branch_tgt;
      redir_mis = 1'b0;
      if (JumpReg) begin
         redir_tgt = jreg_tgt;
         redir_mis = jreg_mis;
      end else if (Jump) begin
         redir_tgt = jump_tgt;
      end
   end

   // Next-state selection: exception > pending > live redirect > sequential.
   always_comb begin
      pc_d       = pc_q;
      valid_d    = 1'b1;
      flush_d    = 1'b0;
      mis_d      = 1'b0;
      pend_v_d   = pend_v_q;
      pend_tgt_d = pend_tgt_q;
      pend_mis_d = pend_mis_q;
      if (!valid_q) begin
         // First edge out of reset: RESET_VECTOR becomes the first real fetch.
         pc_d = pc_q;
      end else if (Exception) begin
         pc_d       = EXC_PC;
         flush_d    = 1'b1;
         pend_v_d   = 1'b0;
         pend_tgt_d = '0;
         pend_mis_d = 1'b0;
      end else if (Stall) begin
         // Only the oldest redirect is kept; younger ones are wrong-path.
         if (!pend_v_q && redir_any) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = redir_tgt;
            pend_mis_d = redir_mis;
         end
      end else if (pend_v_q) begin
         pc_d       = pend_tgt_q;
         flush_d    = 1'b1;
         mis_d      = pend_mis_q;
         pend_v_d   = 1'b0;
         pend_tgt_d = '0;
         pend_mis_d = 1'b0;
      end else if (redir_any) begin
         pc_d    = redir_tgt;
         flush_d = 1'b1;
         mis_d   = redir_mis;
      end else begin
         pc_d = pc_q + STEP;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge Clk or posedge PcReSet) begin
      if (PcReSet) begin
         pc_q       <= RST_PC;
         valid_q    <= 1'b0;
         flush_q    <= 1'b0;
         mis_q      <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_tgt_q <= '0;
         pend_mis_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         flush_q    <= flush_d;
         mis_q      <= mis_d;
         pend_v_q   <= pend_v_d;
         pend_tgt_q <= pend_tgt_d;
         pend_mis_q <= pend_mis_d;
      end
   end

   assign PC           = pc_q;
   assign PcPlus4      = pc_q + STEP;
   assign FetchValid   = valid_q;
   assign Flush        = flush_q;
   assign Misalign     = mis_q;
   assign RedirPending = pend_v_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected PC/flags queued as each step is
// driven, popped and compared one cycle later after the clock edge.
module tb_pc_fetch_unit;

   logic        Clk = 1'b0;
   logic        PcReSet;
   logic        Stall, Exception, JumpReg, Jump, BranchTaken;
   logic [31:0] JumpRegAddr, RedirBasePc;
   logic [25:0] JumpIndex;
   logic [15:0] BranchOffset;
   logic [31:0] PC, PcPlus4;
   logic        FetchValid, Flush, Misalign, RedirPending;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        vld;
      logic        fl;
      logic        mis;
      logic        pend;
   } exp_t;

   exp_t sb[$];

   pc_fetch_unit dut (
      .Clk(Clk), .PcReSet(PcReSet), .Stall(Stall), .Exception(Exception),
      .JumpReg(JumpReg), .JumpRegAddr(JumpRegAddr), .Jump(Jump),
      .JumpIndex(JumpIndex), .BranchTaken(BranchTaken),
      .BranchOffset(BranchOffset), .RedirBasePc(RedirBasePc),
      .PC(PC), .PcPlus4(PcPlus4), .FetchValid(FetchValid), .Flush(Flush),
      .Misalign(Misalign), .RedirPending(RedirPending)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic clr();
      Stall = 0; Exception = 0; JumpReg = 0; Jump = 0; BranchTaken = 0;
      JumpRegAddr = 0; RedirBasePc = 0; JumpIndex = 0; BranchOffset = 0;
   endtask

   // Compare the current DUT outputs against one expected record.
   task automatic compare(input exp_t e);
      logic [31:0] p4;
      p4 = e.pc + 32'd4;
      checks++;
      assert (PC === e.pc) else begin
         errors++; $error("FAIL %s PC got %h want %h", e.tag, PC, e.pc);
      end
      checks++;
      assert (PcPlus4 === p4) else begin
         errors++; $error("FAIL %s PcPlus4 got %h want %h", e.tag, PcPlus4, p4);
      end
      checks++;
      assert (FetchValid === e.vld) else begin
         errors++; $error("FAIL %s FetchValid got %b want %b", e.tag, FetchValid, e.vld);
      end
      checks++;
      assert (Flush === e.fl) else begin
         errors++; $error("FAIL %s Flush got %b want %b", e.tag, Flush, e.fl);
      end
      checks++;
      assert (Misalign === e.mis) else begin
         errors++; $error("FAIL %s Misalign got %b want %b", e.tag, Misalign, e.mis);
      end
      checks++;
      assert (RedirPending === e.pend) else begin
         errors++; $error("FAIL %s RedirPending got %b want %b", e.tag, RedirPending, e.pend);
      end
      $display("step %-12s PC=%h Flush=%b Mis=%b Pend=%b Valid=%b",
               e.tag, PC, Flush, Misalign, RedirPending, FetchValid);
   endtask

   // Inputs are already driven; queue the expectation, clock once, check.
   task automatic step(input string tag, input logic [31:0] pc_e,
                       input logic vld_e, input logic fl_e,
                       input logic mis_e, input logic pend_e);
      exp_t e;
      e.tag = tag; e.pc = pc_e; e.vld = vld_e; e.fl = fl_e;
      e.mis = mis_e; e.pend = pend_e;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      compare(sb.pop_front());
      clr();
   endtask

   initial begin
      exp_t r;
      clr();
      PcReSet = 1'b1;
      @(posedge Clk); @(posedge Clk); #1;
      r.tag = "reset"; r.pc = 32'h3000; r.vld = 0; r.fl = 0; r.mis = 0; r.pend = 0;
      compare(r);
      PcReSet = 1'b0;

      // 1. reset release and sequential fetch
      step("bringup", 32'h3000, 1, 0, 0, 0);
      step("seq1",    32'h3004, 1, 0, 0, 0);
      step("seq2",    32'h3008, 1, 0, 0, 0);

      // 2. backward taken branch
      BranchTaken = 1; RedirBasePc = 32'h3010; BranchOffset = 16'hFFFC;
      step("branch",  32'h3000, 1, 1, 0, 0);
      step("br_after", 32'h3004, 1, 0, 0, 0);

      // 3. jump during stall is buffered, younger branch dropped
      Stall = 1; Jump = 1; JumpIndex = 26'h000_0100; RedirBasePc = 32'h3020;
      step("stall_jmp", 32'h3004, 1, 0, 0, 1);
      Stall = 1; BranchTaken = 1; RedirBasePc = 32'h5000; BranchOffset = 16'h0010;
      step("stall_drop", 32'h3004, 1, 0, 0, 1);
      BranchTaken = 1; RedirBasePc = 32'h5000; BranchOffset = 16'h0010;
      step("pend_apply", 32'h0400, 1, 1, 0, 0);
      step("pend_after", 32'h0404, 1, 0, 0, 0);

      // 4. exception overrides stall and clears pending
      Stall = 1; Jump = 1; JumpIndex = 26'h000_0100; RedirBasePc = 32'h3020;
      step("stall_jmp2", 32'h0404, 1, 0, 0, 1);
      Stall = 1; Exception = 1;
      step("exc_stall", 32'h4180, 1, 1, 0, 0);
      step("exc_after", 32'h4184, 1, 0, 0, 0);

      // 5. priority jump > branch, jr > jump with misalign
      Jump = 1; JumpIndex = 26'h000_0100; RedirBasePc = 32'h3020;
      BranchTaken = 1; BranchOffset = 16'hFFFC;
      step("jmp_vs_br", 32'h0400, 1, 1, 0, 0);
      JumpReg = 1; JumpRegAddr = 32'h3007; Jump = 1; JumpIndex = 26'h000_0200;
      step("jr_mis",    32'h3004, 1, 1, 1, 0);
      step("jr_after",  32'h3008, 1, 0, 0, 0);
      Stall = 1; JumpReg = 1; JumpRegAddr = 32'h5002;
      step("stall_jr",  32'h3008, 1, 0, 0, 1);
      step("jr_pend",   32'h5000, 1, 1, 1, 0);
      Exception = 1; JumpReg = 1; JumpRegAddr = 32'h6000;
      step("exc_vs_jr", 32'h4180, 1, 1, 0, 0);

      // sequential wrap at the top of the address space
      JumpReg = 1; JumpRegAddr = 32'hFFFF_FFFC;
      step("to_top",    32'hFFFF_FFFC, 1, 1, 0, 0);
      step("wrap",      32'h0000_0000, 1, 0, 0, 0);

      // 6. asynchronous reset mid-stall with a pending redirect
      Stall = 1; Jump = 1; JumpIndex = 26'h000_0100; RedirBasePc = 32'h3020;
      step("stall_jmp3", 32'h0000_0000, 1, 0, 0, 1);
      Stall = 1;
      #2;
      PcReSet = 1'b1;
      #1;
      r.tag = "async_rst"; r.pc = 32'h3000; r.vld = 0; r.fl = 0; r.mis = 0; r.pend = 0;
      compare(r);
      @(posedge Clk); #1;
      PcReSet = 1'b0;
      clr();
      step("rebringup", 32'h3000, 1, 0, 0, 0);
      step("reseq",     32'h3004, 1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
